// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter for four byte sources sharing one UART transmitter
// Optional packet header byte (HDR_BASE | grantee) enabled by defining UART_ARB_HDR_EN.
module uart_tx_arbiter #(
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_last,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic        uart_wr,
  output logic [7:0]  uart_dat,
  input  logic        uart_tx_busy,
  output logic        arb_busy
);

  localparam logic [2:0] IDLE   = 3'd0;
`ifdef UART_ARB_HDR_EN
  localparam logic [2:0] HDR    = 3'd1;
`endif
  localparam logic [2:0] SEND   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  logic [2:0] state;
  logic [1:0] rr_ptr;
  logic [1:0] gidx;
  logic       last_q;
  logic [1:0] win;
  logic       win_vld;
  logic [7:0] cur_dat;

`ifndef UART_ARB_HDR_EN
  // Keeps the header parameter referenced when header support is compiled out.
  logic [7:0] hdr_base_unused;
  assign hdr_base_unused = HDR_BASE;
`endif

  // Descending scan so the requester closest to rr_ptr is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win     = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[rr_ptr + 2'(i)]) begin
        win     = rr_ptr + 2'(i);
        win_vld = 1'b1;
      end
    end
  end

  assign cur_dat = req_dat[{gidx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      ack      <= 4'b0000;
      uart_wr  <= 1'b0;
      uart_dat <= 8'h00;
      arb_busy <= 1'b0;
      rr_ptr   <= 2'd0;
      gidx     <= 2'd0;
      last_q   <= 1'b0;
    end else begin
      uart_wr <= 1'b0;
      ack     <= 4'b0000;
      case (state)
        IDLE: begin
          if (win_vld && !uart_tx_busy) begin
            gidx     <= win;
            grant    <= 4'b0001 << win;
            arb_busy <= 1'b1;
`ifdef UART_ARB_HDR_EN
            state    <= HDR;
`else
            state    <= SEND;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        HDR: begin
          if (!uart_tx_busy) begin
            uart_wr  <= 1'b1;
            uart_dat <= HDR_BASE | {6'b000000, gidx};
            last_q   <= 1'b0;
            state    <= SETTLE;
          end
        end
`endif
        SEND: begin
          if (req[gidx] && !uart_tx_busy) begin
            uart_wr  <= 1'b1;
            ack      <= 4'b0001 << gidx;
            uart_dat <= cur_dat;
            last_q   <= req_last[gidx];
            state    <= SETTLE;
          end
        end
        // The UART busy flag rises one cycle after wr, so it is not trusted here.
        SETTLE: state <= DRAIN;
        DRAIN: begin
          if (!uart_tx_busy) begin
            if (last_q) begin
              state    <= IDLE;
              grant    <= 4'b0000;
              arb_busy <= 1'b0;
              rr_ptr   <= gidx + 2'd1;
            end else begin
              state <= SEND;
            end
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= 4'b0000;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
